vga_text_render: RTL and testbench

- Pixel-pipeline stage directly downstream of the 800x600@60 timing generator. Consumes its hs/vs/h_active/v_active and produces 8-bit RGB plus delayed sync and data-enable for the video output.
- Renders a 100x37 character text screen, 8x16 glyphs, 16-colour CGA palette, with a blinking underline cursor.
- Reads an external text RAM and font ROM. Both are synchronous read with 1-cycle latency.

---
 rtl/vga_text_render.sv | 111 +++++++++++
 tb/tb_vga_text_render.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_text_render.sv
// vga_text_render: 100x37 text-mode pixel pipeline (8x16 glyphs, CGA palette, blinking underline cursor)
// Ports: clock/rst_i; hs_in/vs_in/h_active/v_active from the timing generator;
// text_addr/text_data and font_addr/font_data to 1-cycle-latency synchronous memories;
// cursor_en/cursor_col/cursor_row; vga_r/g/b/hs/vs/de aligned 3 cycles after the inputs.
module vga_text_render #(
  parameter int COLS = 100,
  parameter int ROWS = 37,
  parameter int ADDR_W = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clock,
  input  logic              rst_i,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              h_active,
  input  logic              v_active,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [15:0]       text_data,
  output logic [11:0]       font_addr,
  input  logic [7:0]        font_data,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [5:0]        cursor_row,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de
);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [9:0] x, y;
  logic h_prev, vs_prev, phase;
  logic [BW-1:0] frame_cnt;
  logic [3:0] gr1, fg2, bg2;
  logic [2:0] xl1, xl2, hs_d, vs_d, de_d;
  logic hit1, hit2, ok1, ok2;
  logic [6:0] col;
  logic [5:0] row;
  logic [3:0] gr, idx;
  logic hit0, ok0, pix;
  function automatic logic [7:0] lvl(input logic b, input logic hi);
    return b ? (hi ? 8'hFF : 8'hAA) : (hi ? 8'h55 : 8'h00);
  endfunction
  function automatic logic [23:0] pal(input logic [3:0] i);
    return {lvl(i[2], i[3]), i == 4'd6 ? 8'h55 : lvl(i[1], i[3]), lvl(i[0], i[3])};
  endfunction
  always_comb begin
    col = x[9:3];
    row = y[9:4];
    gr = y[3:0];
    text_addr = ADDR_W'(32'(row) * COLS + 32'(col));
    hit0 = cursor_en & phase & (col == cursor_col) & (row == cursor_row) & (gr[3:1] == 3'b111);
    ok0 = 32'(row) < ROWS;
    // font lookup must be combinational from text_data to keep the fixed 3-cycle latency
    font_addr = rst_i ? 12'd0 : {text_data[7:0], gr1};
    pix = font_data[3'd7 - xl2];
    // cursor swaps fg/bg, which is the same as inverting the glyph bit
    idx = (pix ^ hit2) ? fg2 : bg2;
  end
  always_ff @(posedge clock or posedge rst_i) begin
    if (rst_i) begin
      x <= '0;
      y <= '0;
      h_prev <= 1'b0;
      vs_prev <= 1'b0;
      phase <= 1'b0;
      frame_cnt <= '0;
      gr1 <= '0;
      xl1 <= '0;
      hit1 <= 1'b0;
      ok1 <= 1'b0;
      fg2 <= '0;
      bg2 <= '0;
      xl2 <= '0;
      hit2 <= 1'b0;
      ok2 <= 1'b0;
      hs_d <= '0;
      vs_d <= '0;
      de_d <= '0;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      h_prev <= h_active;
      vs_prev <= vs_in;
      x <= !h_active ? 10'd0 : x + 10'(v_active);
      y <= !v_active ? 10'd0 : y + 10'(h_prev & ~h_active);
      if (vs_in & ~vs_prev) begin
        frame_cnt <= (frame_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : frame_cnt + 1'b1;
        if (frame_cnt == BW'(BLINK_FRAMES - 1)) phase <= ~phase;
      end
      gr1 <= gr;
      xl1 <= x[2:0];
      hit1 <= hit0;
      ok1 <= ok0;
      fg2 <= text_data[11:8];
      bg2 <= text_data[15:12];
      xl2 <= xl1;
      hit2 <= hit1;
      ok2 <= ok1;
      hs_d <= {hs_d[1:0], hs_in};
      vs_d <= {vs_d[1:0], vs_in};
      de_d <= {de_d[1:0], h_active & v_active};
      {vga_r, vga_g, vga_b} <= (de_d[1] & ok2) ? pal(idx) : 24'd0;
    end
  end
  assign vga_hs = hs_d[2];
  assign vga_vs = vs_d[2];
  assign vga_de = de_d[2];
endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: scoreboard bench for vga_text_render with behavioural text RAM / font ROM
module tb_vga_text_render;
  logic clock = 1'b0, rst_i = 1'b1;
  logic hs_in = 0, vs_in = 0, h_active = 0, v_active = 0;
  logic [11:0] text_addr, font_addr;
  logic [15:0] text_data = '0;
  logic [7:0] font_data = '0;
  logic cursor_en = 0;
  logic [6:0] cursor_col = 0;
  logic [5:0] cursor_row = 0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_de;

  vga_text_render dut (
    .clock(clock), .rst_i(rst_i), .hs_in(hs_in), .vs_in(vs_in),
    .h_active(h_active), .v_active(v_active),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] text_fn(input logic [11:0] a);
    return a == 12'd0 ? 16'h1E41 : {a[3:0], a[7:4] + 4'd3, a[7:0]};
  endfunction
  function automatic logic [7:0] font_fn(input logic [11:0] fa);
    return fa[11:4] == 8'h41 ? 8'h81 : fa[11:4] ^ {fa[3:0], ~fa[3:0]};
  endfunction

  always @(posedge clock) begin
    text_data <= text_fn(text_addr);
    font_data <= font_fn(font_addr);
  end

  logic [23:0] cga [16] = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
                            24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
                            24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
                            24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};

  typedef struct { int y; int x; int addr; } addr_vec_t;
  typedef struct { logic [23:0] rgb; logic de; logic hs; logic vs; int x; int y; } exp_t;
  addr_vec_t atab [8];
  bit ahit [8];
  logic [23:0] ptab [8];
  exp_t sb [$];
  int n_chk = 0, n_fail = 0;
  int bx, by, bcnt;
  bit hp, vp, ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (model x=%0d y=%0d t=%0t)", name, act, req, bx, by, $time);
    end
  endtask

  task automatic rst_model();
    exp_t z;
    z = '{24'd0, 1'b0, 1'b0, 1'b0, -1, -1};
    bx = 0; by = 0; bcnt = 0; hp = 0; vp = 0; ph = 0;
    sb.delete();
    repeat (3) sb.push_back(z);
  endtask

  task automatic tick(input logic h, input logic v, input logic hs, input logic vs);
    exp_t e;
    int r, c, g;
    logic [11:0] a;
    logic [15:0] td;
    logic [7:0] fd;
    logic pb, hit;
    logic [3:0] idx;
    e = sb.pop_front();
    chk("pixel", {5'd0, vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs}, {5'd0, e.rgb, e.de, e.hs, e.vs});
    if (e.de && e.y == 0 && e.x >= 0 && e.x < 8) chk("pix_tbl", {8'd0, vga_r, vga_g, vga_b}, {8'd0, ptab[e.x]});
    if (e.de && e.y >= 592) chk("below_text", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    r = by >> 4; c = bx >> 3; g = by & 15;
    a = 12'(r * 100 + c);
    chk("text_addr", {20'd0, text_addr}, {20'd0, a});
    for (int i = 0; i < 8; i++)
      if (h && v && bx == atab[i].x && by == atab[i].y) begin
        ahit[i] = 1;
        chk("addr_tbl", {20'd0, text_addr}, 32'(atab[i].addr));
      end
    h_active = h; v_active = v; hs_in = hs; vs_in = vs;
    td = text_fn(a);
    fd = font_fn({td[7:0], 4'(g)});
    pb = fd[7 - (bx & 7)];
    hit = cursor_en && ph && c == int'(cursor_col) && r == int'(cursor_row) && g >= 14;
    idx = (pb ^ hit) ? td[11:8] : td[15:12];
    e.rgb = (h && v && r < 37) ? cga[idx] : 24'd0;
    e.de = h & v; e.hs = hs; e.vs = vs; e.x = bx; e.y = by;
    sb.push_back(e);
    if (vs && !vp) begin
      if (bcnt == 29) begin bcnt = 0; ph = !ph; end
      else bcnt++;
    end
    vp = vs;
    by = !v ? 0 : by + int'(hp && !h);
    bx = !h ? 0 : bx + int'(v);
    hp = h;
    @(negedge clock);
  endtask

  task automatic line(input int len, input logic v, input logic vs);
    for (int i = 0; i < len; i++) tick(1, v, 0, vs);
    for (int i = 0; i < 4; i++) tick(0, v, i == 1, vs);
  endtask

  task automatic frame(input int n);
    for (int l = 0; l < n; l++) line(l == 576 ? 800 : 48, 1, 0);
    line(48, 0, 1);
    line(48, 0, 0);
  endtask

  task automatic vpulse();
    repeat (2) tick(0, 0, 0, 1);
    repeat (2) tick(0, 0, 0, 0);
  endtask

  initial begin
    atab = '{'{0, 0, 0}, '{0, 7, 0}, '{0, 8, 1}, '{0, 15, 1},
             '{16, 0, 100}, '{576, 792, 3699}, '{46, 40, 205}, '{47, 47, 205}};
    ptab = '{24'hFFFF55, 24'h0000AA, 24'h0000AA, 24'h0000AA,
             24'h0000AA, 24'h0000AA, 24'h0000AA, 24'hFFFF55};
    cursor_en = 1; cursor_col = 7'd5; cursor_row = 6'd2;
    repeat (3) @(negedge clock);
    chk("reset_rgb", {5'd0, vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs}, 32'd0);
    chk("reset_addr", {8'd0, text_addr, font_addr}, 32'd0);
    rst_i = 0;
    rst_model();
    repeat (3) line(48, 1, 0);
    repeat (10) tick(1, 1, 0, 0);
    #2 rst_i = 1;
    #1;
    chk("async_rst_rgb", {5'd0, vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs}, 32'd0);
    chk("async_rst_addr", {8'd0, text_addr, font_addr}, 32'd0);
    h_active = 0; v_active = 0; hs_in = 0; vs_in = 0;
    repeat (3) @(negedge clock);
    chk("held_rst_rgb", {5'd0, vga_r, vga_g, vga_b, vga_de, vga_hs, vga_vs}, 32'd0);
    rst_i = 0;
    rst_model();
    repeat (2) tick(0, 0, 0, 0);
    frame(600);
    repeat (28) vpulse();
    frame(48);
    frame(48);
    cursor_en = 0;
    frame(48);
    repeat (4) tick(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk("addr_tbl_seen", 32'(ahit[i]), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
